// File: rtl/ex_stage_md.sv
// ex_stage_md -- execute stage of the soft-core pipeline.
//
// Resolves operand forwarding and runs a single-cycle ALU with a stored
// {N,Z,C,V} flags register. MUL/DIVU/REMU go to an iterative unit that
// takes one bit per cycle and stalls the upstream pipeline meanwhile.
// The stage drives the EX/MEM pipeline register directly.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ID_EX_*                  instruction, operands and control from ID/EX
//   ForwardA/B               00/11 register, 10 EX_Data, 01 MEM_Data
//   EX_Data, MEM_Data        forwarded values
//   Flush                    kill the instruction in EX
//   Stall                    hold PC, IF/ID and ID/EX
//   BranchTaken/Target       combinational branch decision and target
//   Flags                    stored {N,Z,C,V}
//   EX_MEM_*                 registered outputs to the MEM stage
module ex_stage_md #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_Valid,
  input  logic [3:0]        ID_EX_Op,
  input  logic              ID_EX_ALUSrc,
  input  logic              ID_EX_SetFlags,
  input  logic              ID_EX_Branch,
  input  logic              ID_EX_MemToReg,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic [XLEN-1:0]   ID_EX_ReadData1,
  input  logic [XLEN-1:0]   ID_EX_ReadData2,
  input  logic [XLEN-1:0]   ID_EX_Imm,
  input  logic [REG_AW-1:0] ID_EX_WriteReg,
  input  logic [XLEN-1:0]   ID_EX_BranchTarget,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [XLEN-1:0]   EX_Data,
  input  logic [XLEN-1:0]   MEM_Data,
  input  logic              Flush,
  output logic              Stall,
  output logic              BranchTaken,
  output logic [XLEN-1:0]   BranchTarget,
  output logic [3:0]        Flags,
  output logic              EX_MEM_Valid,
  output logic              EX_MEM_MemToReg,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemWrite,
  output logic [XLEN-1:0]   EX_MEM_ALUResult,
  output logic [XLEN-1:0]   EX_MEM_WriteData,
  output logic [REG_AW-1:0] EX_MEM_WriteReg
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_md_op;
  logic                r_md_m2r, r_md_rw, r_md_mr, r_md_mw;
  logic [REG_AW-1:0]   r_md_wreg;
  logic [XLEN-1:0]     r_md_wdata;
  // MUL: r_opa multiplicand (shifts left), r_opb multiplier (shifts right),
  //      r_acc running product.
  // DIV: r_opa dividend shifting out / quotient shifting in, r_opb divisor,
  //      r_acc partial remainder.
  logic [XLEN-1:0]     r_opa, r_opb, r_acc;
  logic [3:0]          r_flags;

  logic [XLEN-1:0]     r_exm_res, r_exm_wdata;
  logic [REG_AW-1:0]   r_exm_wreg;
  logic                r_exm_vld, r_exm_m2r, r_exm_rw, r_exm_mr, r_exm_mw;

  logic [XLEN-1:0]        w_fwd_a, w_fwd_b, w_a, w_b, w_res, w_md_res;
  logic signed [XLEN-1:0] w_a_s, w_b_s;
  logic [SHW-1:0]         w_shamt;
  logic [XLEN:0]          w_sum, w_dif, w_rem_sh, w_trial;
  logic                   w_c, w_v, w_zero, w_neg, w_lt, w_ge;
  logic                   w_is_md, w_md_en, w_idle, w_busy, w_start, w_flag_ld;

  // Forwarding happens before the ALUSrc mux so an immediate always wins.
  always_comb begin
    case (ForwardA)
      2'b10:   w_fwd_a = EX_Data;
      2'b01:   w_fwd_a = MEM_Data;
      default: w_fwd_a = ID_EX_ReadData1;
    endcase
    case (ForwardB)
      2'b10:   w_fwd_b = EX_Data;
      2'b01:   w_fwd_b = MEM_Data;
      default: w_fwd_b = ID_EX_ReadData2;
    endcase
  end

  assign w_a     = w_fwd_a;
  assign w_b     = ID_EX_ALUSrc ? ID_EX_Imm : w_fwd_b;
  assign w_a_s   = w_a;
  assign w_b_s   = w_b;
  assign w_shamt = w_b[SHW-1:0];
  assign w_lt    = (w_a_s < w_b_s);
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
  // Subtraction as A + ~B + 1: the carry out is set when there is no borrow.
  assign w_dif   = {1'b0, w_a} + {1'b0, ~w_b} + (XLEN+1)'(1);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ID_EX_Op)
      OP_ADD: begin
        w_res = w_sum[XLEN-1:0];
        w_c   = w_sum[XLEN];
        w_v   = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
      end
      OP_SUB: begin
        w_res = w_dif[XLEN-1:0];
        w_c   = w_dif[XLEN];
        w_v   = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_dif[XLEN-1] != w_a[XLEN-1]);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLL:  w_res = w_a << w_shamt;
      OP_SRL:  w_res = w_a >> w_shamt;
      OP_SRA:  w_res = $unsigned(w_a_s >>> w_shamt);
      default: w_res = '0;  // MUL/DIVU/REMU here only when MD is disabled
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_neg  = w_res[XLEN-1];

  assign w_is_md   = (ID_EX_Op == OP_MUL) || (ID_EX_Op == OP_DIVU) || (ID_EX_Op == OP_REMU);
  assign w_md_en   = MD_ENABLE && w_is_md;
  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_BUSY);
  assign w_start   = w_idle && ID_EX_Valid && w_md_en && !Flush;
  assign w_flag_ld = w_idle && ID_EX_Valid && ID_EX_SetFlags && !Flush && !w_md_en;

  // Gated by rst so both read 0 while reset is held, whatever the inputs do.
  assign Stall       = rst && !Flush && (w_start || w_busy);
  assign BranchTaken = rst && ID_EX_Valid && ID_EX_Branch && w_zero && !Flush && w_idle;
  assign BranchTarget = ID_EX_BranchTarget;

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract when it fits. The remainder stays below the
  // divisor, so bit XLEN of the trial is exactly the borrow. A zero divisor
  // always "fits", giving an all-ones quotient and remainder = dividend.
  assign w_rem_sh = {r_acc, r_opa[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_opb};
  assign w_ge     = !w_trial[XLEN];

  assign w_md_res = (r_md_op == OP_DIVU) ? r_opa : r_acc;

  // Iterative datapath: operands and partial results, no reset needed.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_opa      <= w_a;
      r_opb      <= w_b;
      r_acc      <= '0;
      r_md_wdata <= w_fwd_b;
      r_md_wreg  <= ID_EX_WriteReg;
    end else if (w_busy) begin
      if (r_md_op == OP_MUL) begin
        if (r_opb[0]) r_acc <= r_acc + r_opa;
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end else begin
        r_opa <= {r_opa[XLEN-2:0], w_ge};
        r_acc <= w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      end
    end
  end

  // Control state, flags and the EX/MEM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_md_op     <= '0;
      r_md_m2r    <= 1'b0;
      r_md_rw     <= 1'b0;
      r_md_mr     <= 1'b0;
      r_md_mw     <= 1'b0;
      r_flags     <= '0;
      r_exm_vld   <= 1'b0;
      r_exm_m2r   <= 1'b0;
      r_exm_rw    <= 1'b0;
      r_exm_mr    <= 1'b0;
      r_exm_mw    <= 1'b0;
      r_exm_res   <= '0;
      r_exm_wdata <= '0;
      r_exm_wreg  <= '0;
    end else begin
      if (w_flag_ld) r_flags <= {w_neg, w_zero, w_c, w_v};

      if (Flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_state  <= S_BUSY;
            r_cnt    <= '0;
            r_md_op  <= ID_EX_Op;
            r_md_m2r <= ID_EX_MemToReg;
            r_md_rw  <= ID_EX_RegWrite;
            r_md_mr  <= ID_EX_MemRead;
            r_md_mw  <= ID_EX_MemWrite;
          end
          S_BUSY: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN-1)) r_state <= S_DONE;
          end
          // The instruction still sitting in ID/EX is the one just finished.
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end

      // Bubbles clear only the qualifying bits; data fields hold.
      if (Flush || w_busy || (w_idle && (w_start || !ID_EX_Valid))) begin
        r_exm_vld <= 1'b0;
        r_exm_rw  <= 1'b0;
        r_exm_mr  <= 1'b0;
        r_exm_mw  <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_exm_vld   <= 1'b1;
        r_exm_res   <= w_md_res;
        r_exm_wdata <= r_md_wdata;
        r_exm_wreg  <= r_md_wreg;
        r_exm_m2r   <= r_md_m2r;
        r_exm_rw    <= r_md_rw;
        r_exm_mr    <= r_md_mr;
        r_exm_mw    <= r_md_mw;
      end else begin
        r_exm_vld   <= 1'b1;
        r_exm_res   <= w_res;
        r_exm_wdata <= w_fwd_b;
        r_exm_wreg  <= ID_EX_WriteReg;
        r_exm_m2r   <= ID_EX_MemToReg;
        r_exm_rw    <= ID_EX_RegWrite;
        r_exm_mr    <= ID_EX_MemRead;
        r_exm_mw    <= ID_EX_MemWrite;
      end
    end
  end

  assign Flags            = r_flags;
  assign EX_MEM_Valid     = r_exm_vld;
  assign EX_MEM_MemToReg  = r_exm_m2r;
  assign EX_MEM_RegWrite  = r_exm_rw;
  assign EX_MEM_MemRead   = r_exm_mr;
  assign EX_MEM_MemWrite  = r_exm_mw;
  assign EX_MEM_ALUResult = r_exm_res;
  assign EX_MEM_WriteData = r_exm_wdata;
  assign EX_MEM_WriteReg  = r_exm_wreg;

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md (XLEN = 32): the driver pushes the
// expected EX/MEM contents computed by a plain-arithmetic reference model;
// an independent monitor pops and compares whenever EX_MEM_Valid is high.
module tb_ex_stage_md;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              ID_EX_Valid, ID_EX_ALUSrc, ID_EX_SetFlags, ID_EX_Branch;
  logic              ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic [3:0]        ID_EX_Op;
  logic [XLEN-1:0]   ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_BranchTarget;
  logic [REG_AW-1:0] ID_EX_WriteReg;
  logic [1:0]        ForwardA, ForwardB;
  logic [XLEN-1:0]   EX_Data, MEM_Data;
  logic              Flush;
  logic              Stall, BranchTaken;
  logic [XLEN-1:0]   BranchTarget;
  logic [3:0]        Flags;
  logic              EX_MEM_Valid, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic [XLEN-1:0]   EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [REG_AW-1:0] EX_MEM_WriteReg;

  ex_stage_md #(.XLEN(XLEN), .REG_AW(REG_AW), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_Op(ID_EX_Op), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_SetFlags(ID_EX_SetFlags), .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_WriteReg(ID_EX_WriteReg),
    .ID_EX_BranchTarget(ID_EX_BranchTarget),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .EX_Data(EX_Data), .MEM_Data(MEM_Data),
    .Flush(Flush), .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Flags(Flags), .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_MemToReg(EX_MEM_MemToReg),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_WriteReg(EX_MEM_WriteReg)
  );

  typedef struct {
    logic        valid, alusrc, setf, br, m2r, rw, mr, mw, flush;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, tgt, exd, memd;
    logic [4:0]  wreg;
    logic [1:0]  fa, fb;
  } ins_t;

  typedef struct {
    logic [31:0] res, wdata;
    logic        chk_wdata;
    logic [4:0]  wreg;
    logic        m2r, rw, mr, mw;
    logic [3:0]  flags;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                      input logic [31:0] exd, input logic [31:0] memd);
    if (sel == 2'b10) return exd;
    if (sel == 2'b01) return memd;
    return rd;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a << b[4:0];
      4'd7:  return a >> b[4:0];
      4'd8:  return sa >>> b[4:0];
      4'd9:  return a * b;
      4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] r);
    logic [32:0] s;
    logic c, v;
    c = 1'b0; v = 1'b0;
    if (op == 4'd0) begin
      s = {1'b0, a} + {1'b0, b};
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 4'd1) begin
      c = (a >= b);
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {r[31], r == 32'd0, c, v};
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return op == 4'd9 || op == 4'd10 || op == 4'd11;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input ins_t t);
    ID_EX_Valid = t.valid; ID_EX_Op = t.op; ID_EX_ALUSrc = t.alusrc;
    ID_EX_SetFlags = t.setf; ID_EX_Branch = t.br; ID_EX_MemToReg = t.m2r;
    ID_EX_RegWrite = t.rw; ID_EX_MemRead = t.mr; ID_EX_MemWrite = t.mw;
    ID_EX_ReadData1 = t.rd1; ID_EX_ReadData2 = t.rd2; ID_EX_Imm = t.imm;
    ID_EX_WriteReg = t.wreg; ID_EX_BranchTarget = t.tgt; ForwardA = t.fa;
    ForwardB = t.fb; EX_Data = t.exd; MEM_Data = t.memd; Flush = t.flush;
  endtask

  function automatic ins_t nop();
    ins_t t;
    t = '{default: '0};
    return t;
  endfunction

  // Presents an instruction, holds it while Stall is high, returns after the
  // edge on which ID/EX would advance (at posedge + 1).
  task automatic issue(input ins_t t);
    logic [31:0] a, b, fb, r;
    logic        live, md, exp_bt, st;
    int          stalls, cyc;
    exp_t        e;
    drive(t);
    fb   = fwd(t.fb, t.rd2, t.exd, t.memd);
    a    = fwd(t.fa, t.rd1, t.exd, t.memd);
    b    = t.alusrc ? t.imm : fb;
    r    = ref_res(t.op, a, b);
    md   = is_md(t.op);
    live = t.valid && !t.flush;
    exp_bt = live && t.br && (r == 32'd0);
    if (live) begin
      if (!md && t.setf) m_flags = ref_flags(t.op, a, b, r);
      e.res = r; e.wdata = fb; e.chk_wdata = !md; e.wreg = t.wreg;
      e.m2r = t.m2r; e.rw = t.rw; e.mr = t.mr; e.mw = t.mw; e.flags = m_flags;
      sbq.push_back(e);
    end
    stalls = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("branch_taken", {31'd0, BranchTaken}, {31'd0, exp_bt});
        chk("branch_target", BranchTarget, t.tgt);
      end
      st = Stall;
      if (st) stalls++;
      @(posedge clk);
      #1;
      cyc++;
      if (!st) break;
      if (cyc > XLEN + 10) begin
        checks++; errors++;
        $display("FAIL stall_timeout actual=%0d required=%0d", cyc, XLEN + 1);
        break;
      end
    end
    chk("stall_cycles", stalls, (live && md) ? XLEN + 1 : 0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int v;
    t.valid = ($urandom_range(0, 9) != 0);
    t.flush = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 9) == 0) t.op = 4'(9 + $urandom_range(0, 2));
    else begin
      v = $urandom_range(0, 12);
      t.op = (v < 9) ? 4'(v) : 4'(v + 3);
    end
    t.alusrc = $urandom_range(0, 1); t.setf = $urandom_range(0, 1);
    t.br = !is_md(t.op) && ($urandom_range(0, 3) == 0);
    t.m2r = $urandom_range(0, 1); t.rw = $urandom_range(0, 1);
    t.mr = $urandom_range(0, 1); t.mw = $urandom_range(0, 1);
    t.rd1 = rand_val(); t.rd2 = rand_val(); t.imm = rand_val();
    t.exd = rand_val(); t.memd = rand_val(); t.tgt = $urandom;
    t.wreg = 5'($urandom_range(0, 31));
    t.fa = 2'($urandom_range(0, 3)); t.fb = 2'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic ins_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] wreg);
    ins_t t;
    t = nop();
    t.valid = 1'b1; t.op = op; t.rd1 = a; t.rd2 = b; t.wreg = wreg; t.rw = 1'b1;
    t.tgt = 32'h0000_1000;
    return t;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst && EX_MEM_Valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%h required=none", EX_MEM_ALUResult);
        end else begin
          mon_e = sbq.pop_front();
          chk("alu_result", EX_MEM_ALUResult, mon_e.res);
          if (mon_e.chk_wdata) chk("write_data", EX_MEM_WriteData, mon_e.wdata);
          chk("write_reg", {27'd0, EX_MEM_WriteReg}, {27'd0, mon_e.wreg});
          chk("ctrl", {28'd0, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite},
              {28'd0, mon_e.m2r, mon_e.rw, mon_e.mr, mon_e.mw});
          chk("flags", {28'd0, Flags}, {28'd0, mon_e.flags});
        end
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, EX_MEM_Valid}, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite}, 32'd0);
    chk({tag, "_result"}, EX_MEM_ALUResult, 32'd0);
    chk({tag, "_wdata"}, EX_MEM_WriteData, 32'd0);
    chk({tag, "_wreg"}, {27'd0, EX_MEM_WriteReg}, 32'd0);
    chk({tag, "_flags"}, {28'd0, Flags}, 32'd0);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
    chk({tag, "_branch"}, {31'd0, BranchTaken}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ins_t t;
    drive(nop());
    // Under reset: a live MUL with Branch set must not raise Stall/BranchTaken.
    t = mk(4'd9, 32'd3, 32'd0, 5'd1);
    t.br = 1'b1;
    drive(t);
    #12;
    chk_zero_outputs("reset_init");
    drive(nop());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow with flags: 0x7FFFFFFF + 1.
    t = mk(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3);
    t.setf = 1'b1;
    issue(t);
    // Forwarded B into WriteData while the immediate feeds the ALU.
    t = mk(4'd0, 32'd1, 32'h99, 5'd4);
    t.fb = 2'b10; t.alusrc = 1'b1; t.imm = 32'd4; t.exd = 32'h55; t.mw = 1'b1;
    issue(t);
    // Multiply/divide, back to back.
    issue(mk(4'd9, 32'h0000_FFFF, 32'h0001_0001, 5'd5));
    issue(mk(4'd10, 32'd100, 32'd0, 5'd6));
    issue(mk(4'd11, 32'd100, 32'd0, 5'd7));
    issue(mk(4'd10, 32'd100, 32'd7, 5'd8));
    issue(mk(4'd11, 32'd100, 32'd7, 5'd9));
    // BEQ as SUB with equal operands, then the same under Flush.
    t = mk(4'd1, 32'h1234, 32'h1234, 5'd0);
    t.br = 1'b1; t.rw = 1'b0;
    issue(t);
    t.flush = 1'b1;
    issue(t);

    // Flush while BUSY at count 10: the MUL result must never appear.
    t = mk(4'd9, 32'd7, 32'd9, 5'd10);
    drive(t);
    @(negedge clk);
    chk("flush_md_stall_start", {31'd0, Stall}, 32'd1);
    repeat (11) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk);
    #1;
    drive(nop());
    @(negedge clk);
    chk("flush_after_stall", {31'd0, Stall}, 32'd0);
    chk("flush_after_valid", {31'd0, EX_MEM_Valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) issue(rand_ins());
    issue(nop());
    issue(nop());

    // Asynchronous reset mid-cycle with a live ADD presented.
    t = mk(4'd0, 32'd5, 32'd6, 5'd11);
    t.setf = 1'b1;
    drive(t);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset_hold");
    drive(nop());
    m_flags = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(mk(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd12));
    issue(nop());
    issue(nop());
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
